matrix_loader: RTL and testbench

Operand loader for the matrix multiply datapath: the producer side of the `cf_load` interface that the multiply controller consumes. It accepts a stream of matrix elements over a valid/ready handshake and writes matrix A, then matrix B, into the operand register file. It then pulses `cf_load` to start a multiply and holds off the next frame until the controller reports the result with `output_set`.

---
 rtl/matrix_loader.sv | 116 +++++++++++
 tb/tb_matrix_loader.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_loader.sv
// Operand loader: streams A then B into the operand register file, pulses
// cf_load to start a multiply, then holds off the next frame until output_set.
module matrix_loader #(
  parameter int DATA_W = 8,
  parameter int N      = 2,
  parameter int ADDR_W = $clog2(2 * N * N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  input  logic              mem_clr,
  input  logic              output_set,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              cf_load,
  output logic              busy,
  output logic              frame_err,
  output logic [2:0]        dbg_state
);

  // Handshake: an element transfers on a rising edge where in_valid & in_ready.
  // in_ready depends only on registered state, gated by mem_clr.

  localparam int FRAME = 2 * N * N;
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(FRAME - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FILL   = 3'd1,
    S_COMMIT = 3'd2,
    S_LOAD   = 3'd3,
    S_WAIT   = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                accept;

  assign in_ready = (state_q == S_FILL) && !mem_clr;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    wr_en_d   = accept;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    if (accept) begin
      wr_addr_d = cnt_q[ADDR_W-1:0];
      wr_data_d = in_data;
    end

    unique case (state_q)
      S_IDLE: state_d = S_FILL;
      S_FILL: begin
        if (mem_clr) begin
          cnt_d = '0;
        end else if (accept) begin
          if (cnt_q == LAST_IDX) begin
            // A final element without in_last is still committed, just flagged.
            state_d = S_COMMIT;
            cnt_d   = '0;
            if (!in_last) err_d = 1'b1;
          end else if (in_last) begin
            // Early in_last: the element is written but the partial frame is dropped.
            err_d = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_COMMIT: state_d = S_LOAD;
      S_LOAD:   state_d = S_WAIT;
      S_WAIT:   if (output_set) state_d = S_FILL;
      default:  state_d = S_IDLE;
    endcase
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign cf_load   = (state_q == S_LOAD);
  assign busy      = (state_q == S_WAIT);
  assign frame_err = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_matrix_loader.sv
// Self-checking bench for matrix_loader: a vector table for the first frames,
// hand sequences for the corner cases, then random traffic against a frame model.
module tb_matrix_loader;
  localparam int DATA_W = 8;
  localparam int N      = 2;
  localparam int FRAME  = 2 * N * N;
  localparam int ADDR_W = 3;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;
  logic              mem_clr;
  logic              output_set;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              cf_load;
  logic              busy;
  logic              frame_err;
  logic [2:0]        dbg_state;

  matrix_loader #(.DATA_W(DATA_W), .N(N), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .mem_clr(mem_clr),
    .output_set(output_set), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .cf_load(cf_load), .busy(busy),
    .frame_err(frame_err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int n_wr  = 0;
  int n_cf  = 0;
  logic [DATA_W+ADDR_W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Frame-level view: started = one cycle has passed since reset release,
  // pos = elements held of the current frame, since = cycles since the frame
  // completed (0 while filling, 1 commit, 2 start pulse, 3 waiting on result).
  bit m_started;
  int m_pos;
  int m_since;
  bit m_err;

  task automatic model_reset();
    m_started = 0;
    m_pos     = 0;
    m_since   = 0;
    m_err     = 0;
    exp_q.delete();
  endtask

  function automatic bit m_ready(input bit clr);
    return m_started && (m_since == 0) && !clr;
  endfunction

  // ---------------- driver ----------------
  bit cur_clr;

  task automatic drive_sample(input bit v, input logic [7:0] d, input bit last,
                              input bit clr, input bit oset);
    in_valid   = v;
    in_data    = d;
    in_last    = last;
    mem_clr    = clr;
    output_set = oset;
    cur_clr    = clr;
    #4;
    chk("in_ready", in_ready, m_ready(clr));
    chk("wr_en", wr_en, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      chk("wr_addr", wr_addr, exp_q[0][DATA_W+ADDR_W-1:DATA_W]);
      chk("wr_data", wr_data, exp_q[0][DATA_W-1:0]);
    end
    chk("cf_load", cf_load, m_since == 2);
    chk("busy", busy, m_since == 3);
    chk("frame_err", frame_err, m_err);
    if (wr_en) n_wr++;
    if (cf_load) n_cf++;
  endtask

  task automatic advance();
    bit acc;
    acc = in_valid && m_ready(cur_clr);
    exp_q.delete();
    if (acc) exp_q.push_back({ADDR_W'(m_pos), in_data});
    if (!m_started) begin
      m_started = 1;
    end else if (m_since == 0) begin
      if (acc) begin
        if (m_pos == FRAME - 1) begin
          if (!in_last) m_err = 1;
          m_pos   = 0;
          m_since = 1;
        end else if (in_last) begin
          m_err = 1;
          m_pos = 0;
        end else begin
          m_pos++;
        end
      end else if (cur_clr) begin
        m_pos = 0;
      end
    end else if (m_since < 3) begin
      m_since++;
    end else if (output_set) begin
      m_since = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit last,
                      input bit clr, input bit oset);
    drive_sample(v, d, last, clr, oset);
    advance();
  endtask

  // Called at edge+1: drops reset between edges and checks outputs clear at once.
  task automatic do_reset();
    #3;
    reset = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_cf_load", cf_load, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_err", frame_err, 0);
    in_valid = 0; in_last = 0; mem_clr = 0; output_set = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("rst_hold_cf_load", cf_load, 0);
      chk("rst_hold_wr_en", wr_en, 0);
    end
    reset = 1'b1;
    model_reset();
  endtask

  task automatic send(input logic [7:0] d, input bit last);
    int guard = 0;
    while (!m_ready(0) && guard < 20) begin
      step(0, 8'h00, 0, 0, m_since == 3);
      guard++;
    end
    if (guard >= 20) chk("send_timeout", guard, 0);
    step(1, d, last, 0, 0);
  endtask

  task automatic finish_frame();
    step(0, 8'h00, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    step(0, 8'h00, 0, 0, 1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit         v;
    logic [7:0] d;
    bit         last;
    bit         clr;
    bit         oset;
    bit         e_ready;
    bit         e_wr;
    logic [2:0] e_addr;
    logic [7:0] e_data;
    bit         e_cf;
    bit         e_busy;
  } vec_t;

  vec_t tbl[18];

  initial begin
    // v  d      last clr oset | ready wr addr data cf busy
    tbl[0]  = '{1, 8'h01, 0, 0, 0, 0, 0, 3'd0, 8'h00, 0, 0};
    for (int i = 1; i <= 8; i++)
      tbl[i] = '{1, 8'(i), i == 8, 0, 0, 1, i > 1, 3'(i - 2), 8'(i - 1), 0, 0};
    tbl[9]  = '{1, 8'h09, 0, 0, 0, 0, 1, 3'd7, 8'h08, 0, 0};
    tbl[10] = '{0, 8'h00, 0, 0, 0, 0, 0, 3'd0, 8'h00, 1, 0};
    tbl[11] = '{1, 8'h99, 0, 0, 0, 0, 0, 3'd0, 8'h00, 0, 1};
    tbl[12] = '{1, 8'h98, 0, 0, 1, 0, 0, 3'd0, 8'h00, 0, 1};
    tbl[13] = '{1, 8'h11, 0, 0, 0, 1, 0, 3'd0, 8'h00, 0, 0};
    tbl[14] = '{0, 8'h00, 0, 0, 0, 1, 1, 3'd0, 8'h11, 0, 0};
    tbl[15] = '{1, 8'h22, 0, 1, 0, 0, 0, 3'd0, 8'h00, 0, 0};
    tbl[16] = '{1, 8'h33, 0, 0, 0, 1, 0, 3'd0, 8'h00, 0, 0};
    tbl[17] = '{0, 8'h00, 0, 0, 0, 1, 1, 3'd0, 8'h33, 0, 0};

    reset = 1'b0; in_valid = 0; in_data = 0; in_last = 0;
    mem_clr = 0; output_set = 0; cur_clr = 0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Reset, full frame, completion handshake, mem_clr mid-frame
    for (int i = 0; i < 18; i++) begin
      drive_sample(tbl[i].v, tbl[i].d, tbl[i].last, tbl[i].clr, tbl[i].oset);
      chk($sformatf("tbl%0d_ready", i), in_ready, tbl[i].e_ready);
      chk($sformatf("tbl%0d_wr_en", i), wr_en, tbl[i].e_wr);
      if (tbl[i].e_wr) begin
        chk($sformatf("tbl%0d_addr", i), wr_addr, tbl[i].e_addr);
        chk($sformatf("tbl%0d_data", i), wr_data, tbl[i].e_data);
      end
      chk($sformatf("tbl%0d_cf", i), cf_load, tbl[i].e_cf);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
      advance();
    end
    step(0, 8'h00, 0, 1, 0);

    // Bubbles across a whole frame
    n_wr = 0; n_cf = 0;
    for (int i = 0; i < 16; i++)
      step(i % 2 == 0, 8'(8'h40 + i / 2), i == 14, 0, 0);
    finish_frame();
    chk("bubble_writes", n_wr, 8);
    chk("bubble_cf_count", n_cf, 1);

    // Early in_last on element 3
    n_cf = 0;
    send(8'h50, 0); send(8'h51, 0); send(8'h52, 1);
    send(8'h53, 0);
    drive_sample(0, 8'h00, 0, 0, 0);
    chk("early_last_next_addr", wr_addr, 0);
    chk("early_last_err", frame_err, 1);
    advance();
    chk("early_last_no_cf", n_cf, 0);

    // mem_clr during WAIT is ignored
    step(0, 8'h00, 0, 1, 0);
    for (int i = 0; i < FRAME; i++) send(8'(8'h60 + i), i == FRAME - 1);
    step(0, 8'h00, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    drive_sample(1, 8'h77, 0, 1, 0);
    chk("wait_clr_busy", busy, 1);
    advance();
    step(1, 8'h78, 0, 1, 0);
    step(0, 8'h00, 0, 0, 1);
    send(8'h79, 0);
    step(0, 8'h00, 0, 0, 0);

    // Final element without in_last: flagged but still committed
    do_reset();
    n_cf = 0;
    for (int i = 0; i < FRAME; i++) send(8'(8'h80 + i), 0);
    finish_frame();
    chk("nolast_cf_count", n_cf, 1);
    chk("nolast_err", frame_err, 1);

    // Asynchronous reset mid-frame
    do_reset();
    step(0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 4; i++) send(8'(8'h90 + i), 0);
    do_reset();
    n_cf = 0;
    send(8'hA0, 0);
    drive_sample(0, 8'h00, 0, 0, 0);
    chk("post_reset_addr", wr_addr, 0);
    advance();
    chk("post_reset_no_cf", n_cf, 0);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      bit v, last, clr, oset;
      v    = $urandom_range(0, 3) != 0;
      last = (m_pos == FRAME - 1) ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 40) == 0);
      clr  = $urandom_range(0, 30) == 0;
      oset = $urandom_range(0, 3) == 0;
      step(v, 8'($urandom), last, clr, oset);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
